// File: rtl/switch_conditioner.sv
// Two-flop synchroniser plus shared-tick debounce of 16 slide switches, with change pulse/mask.
// Defining SW_CHANGE_IRQ_EN adds a latched change interrupt; otherwise IRQ is tied low.
module switch_conditioner #(
    parameter int TICK_DIV       = 100000,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] SW_RAW,
    output logic [7:0]  SWH,
    output logic [7:0]  SWL,
    output logic        VALID,
    output logic        CHANGED,
    output logic [15:0] CHANGE_MASK,
    output logic        IRQ,
    input  logic        IRQ_ACK
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int WW = $clog2(STABLE_SAMPLES);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [WW-1:0] WARM_LAST = WW'(STABLE_SAMPLES - 1);

    typedef enum logic {
        WARMUP,
        RUN
    } state_t;

    state_t                             state_q, state_d;
    logic [15:0]                        meta_q, sync_q;
    logic [TW-1:0]                      tick_cnt_q, tick_cnt_d;
    logic                               tick;
    logic [WW-1:0]                      warm_cnt_q, warm_cnt_d;
    logic [15:0][STABLE_SAMPLES-1:0]    hist_q, hist_d;
    logic [15:0]                        sw_q, sw_d;
    logic [15:0]                        mask_q, mask_d;
    logic                               changed_q, changed_d;

    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        hist_d     = hist_q;
        sw_d       = sw_q;
        if (tick) begin
            for (int b = 0; b < 16; b++) begin
                hist_d[b] = {hist_q[b][STABLE_SAMPLES-2:0], sync_q[b]};
                // Partial agreement holds the previous level, which is what rejects bounce.
                if (&hist_d[b]) begin
                    sw_d[b] = 1'b1;
                end else if (~|hist_d[b]) begin
                    sw_d[b] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        mask_d     = '0;
        case (state_q)
            WARMUP: begin
                if (tick) begin
                    if (warm_cnt_q == WARM_LAST) begin
                        state_d = RUN;
                    end else begin
                        warm_cnt_d = warm_cnt_q + 1'b1;
                    end
                end
            end
            RUN: begin
                if (tick) begin
                    mask_d = sw_q ^ sw_d;
                end
            end
            default: state_d = WARMUP;
        endcase
        changed_d = |mask_d;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= WARMUP;
            meta_q     <= '0;
            sync_q     <= '0;
            tick_cnt_q <= '0;
            warm_cnt_q <= '0;
            hist_q     <= '0;
            sw_q       <= '0;
            mask_q     <= '0;
            changed_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            meta_q     <= SW_RAW;
            sync_q     <= meta_q;
            tick_cnt_q <= tick_cnt_d;
            warm_cnt_q <= warm_cnt_d;
            hist_q     <= hist_d;
            sw_q       <= sw_d;
            mask_q     <= mask_d;
            changed_q  <= changed_d;
        end
    end

    assign SWH         = sw_q[15:8];
    assign SWL         = sw_q[7:0];
    assign VALID       = (state_q == RUN);
    assign CHANGED     = changed_q;
    assign CHANGE_MASK = mask_q;

`ifdef SW_CHANGE_IRQ_EN
    logic irq_q;

    // A change arriving on the acknowledge edge wins so no event is dropped.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= changed_d | (irq_q & ~IRQ_ACK);
        end
    end

    assign IRQ = irq_q;
`else
    assign IRQ = 1'b0 & IRQ_ACK;
`endif

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: directed test-plan scenarios plus random switch activity,
// checked by a scoreboard fed from a sample-window reference model.
module tb_switch_conditioner;

    localparam int TD = 4;
    localparam int NS = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sw_raw = 16'h0001;
    logic        irq_ack = 1'b0;
    logic [7:0]  swh, swl;
    logic        valid, changed, irq;
    logic [15:0] cmask;

    always #5 clk = ~clk;

    switch_conditioner #(.TICK_DIV(TD), .STABLE_SAMPLES(NS)) dut (
        .CLK(clk), .RESET(rst), .SW_RAW(sw_raw),
        .SWH(swh), .SWL(swl), .VALID(valid), .CHANGED(changed),
        .CHANGE_MASK(cmask), .IRQ(irq), .IRQ_ACK(irq_ack)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: sync delay of two edges, samples taken every TD edges,
    // a bit follows its input once the last NS samples all agree.
    typedef struct packed {
        logic [15:0] mask;
        logic [15:0] val;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] raw_log[$];
    logic [15:0] samples[$];
    int          edge_cnt = 0;
    int          m_ticks = 0;
    logic [15:0] m_sw = '0;
    logic        m_valid = 1'b0;
    logic        m_irq = 1'b0;
    logic [15:0] s, nv;
    logic        chg;
    int          ones;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            edge_cnt = 0;
            m_ticks  = 0;
            m_sw     = '0;
            m_valid  = 1'b0;
            m_irq    = 1'b0;
            raw_log.delete();
            exp_q.delete();
            samples.delete();
            repeat (NS) samples.push_back(16'h0);
        end else begin
            edge_cnt++;
            raw_log.push_back(sw_raw);
            chg = 1'b0;
            if (edge_cnt % TD == 0) begin
                s = (edge_cnt >= 3) ? raw_log[edge_cnt-3] : 16'h0;
                samples.push_back(s);
                void'(samples.pop_front());
                nv = m_sw;
                for (int b = 0; b < 16; b++) begin
                    ones = 0;
                    foreach (samples[i]) ones += int'(samples[i][b]);
                    if (ones == NS) nv[b] = 1'b1;
                    else if (ones == 0) nv[b] = 1'b0;
                end
                m_ticks++;
                if (m_valid && nv != m_sw) begin
                    exp_q.push_back(exp_t'({nv ^ m_sw, nv}));
                    chg = 1'b1;
                end
                m_sw = nv;
                if (m_ticks == NS) m_valid = 1'b1;
            end
            m_irq = chg | (m_irq & ~irq_ack);
        end
    end

    // Monitor: compares every cycle, pops the scoreboard on each CHANGED pulse.
    int          pulse_cnt = 0;
    logic [15:0] last_mask = '0;
    exp_t        e;

    initial forever begin
        @(negedge clk);
        check("sw_value", 32'({swh, swl}), 32'(m_sw));
        check("valid", 32'(valid), 32'(m_valid));
`ifdef SW_CHANGE_IRQ_EN
        check("irq", 32'(irq), 32'(m_irq));
`else
        check("irq_tied_low", 32'(irq), 32'd0);
`endif
        if (changed) begin
            pulse_cnt++;
            last_mask = cmask;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_change: mask %0h, required no pulse", cmask);
            end else begin
                e = exp_q.pop_front();
                check("change_mask", 32'(cmask), 32'(e.mask));
                check("change_val", 32'({swh, swl}), 32'(e.val));
            end
        end else begin
            check("idle_mask", 32'(cmask), 32'd0);
            check("missed_change", 32'(exp_q.size()), 32'd0);
        end
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL global_timeout: run did not complete");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

    int pc0;
    int n;

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_swh"}, 32'(swh), 32'd0);
        check({tag, "_swl"}, 32'(swl), 32'd0);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_changed"}, 32'(changed), 32'd0);
        check({tag, "_mask"}, 32'(cmask), 32'd0);
        check({tag, "_irq"}, 32'(irq), 32'd0);
    endtask

    initial begin
        // Reset and warm-up
        step(3);
        check_zero_outputs("reset");
        rst = 1'b0;
        step(11);
        check("valid_before_12", 32'(valid), 32'd0);
        step(1);
        check("valid_at_12", 32'(valid), 32'd1);
        check("warm_swl", 32'(swl), 32'h01);
        check("warm_swh", 32'(swh), 32'h00);
        check("warm_no_pulse", 32'(pulse_cnt), 32'd0);

        // Clean change
        step(5);
        pc0 = pulse_cnt;
        sw_raw = 16'hFF01;
        n = 0;
        while (swh != 8'hFF && n < 20) begin step(1); n++; end
        check("clean_latency_in_11_14", 32'(n >= 11 && n <= 14), 32'd1);
        check("clean_swl_kept", 32'(swl), 32'h01);
        step(2);
        check("clean_one_pulse", 32'(pulse_cnt - pc0), 32'd1);
        check("clean_mask", 32'(last_mask), 32'hFF00);

        // Bounce on bit 0
        pc0 = pulse_cnt;
        for (int i = 0; i < 12; i++) begin
            sw_raw[0] = ~sw_raw[0];
            repeat (5) begin
                step(1);
                check("bounce_swl0", 32'(swl[0]), 32'd1);
            end
        end
        check("bounce_no_pulse", 32'(pulse_cnt - pc0), 32'd0);
        sw_raw[0] = 1'b0;
        n = 0;
        while (swl != 8'h00 && n < 20) begin step(1); n++; end
        check("bounce_settle_le14", 32'(n <= 14), 32'd1);
        step(2);
        check("bounce_mask", 32'(last_mask), 32'h0001);

        // Glitch on bit 9 aligned to a sample tick
        sw_raw = 16'h0000;
        step(20);
        n = 0;
        while ((edge_cnt + 3) % TD != 0 && n < TD) begin step(1); n++; end
        pc0 = pulse_cnt;
        sw_raw[9] = 1'b1;
        step(1);
        sw_raw[9] = 1'b0;
        step(20);
        check("glitch_swh", 32'(swh), 32'h00);
        check("glitch_no_pulse", 32'(pulse_cnt - pc0), 32'd0);

        // Interrupt behaviour
`ifdef SW_CHANGE_IRQ_EN
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        check("irq_idle", 32'(irq), 32'd0);
        sw_raw = 16'h0010;
        n = 0;
        while (!changed && n < 20) begin step(1); n++; end
        check("irq_set", 32'(irq), 32'd1);
        irq_ack = 1'b1;
        step(1);
        check("irq_ack_clears", 32'(irq), 32'd0);
        sw_raw = 16'h0000;
        n = 0;
        while (!changed && n < 20) begin step(1); n++; end
        check("irq_ack_with_change", 32'(irq), 32'd1);
        step(1);
        check("irq_ack_after", 32'(irq), 32'd0);
        irq_ack = 1'b0;
`else
        sw_raw = 16'h0010;
        n = 0;
        while (!changed && n < 20) begin step(1); n++; end
        check("irq_off_on_change", 32'(irq), 32'd0);
`endif
        check("irq_change_seen", 32'(n < 20), 32'd1);

        // Random activity
        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 2))
                0: sw_raw = 16'($urandom);
                1: sw_raw = sw_raw ^ (16'h1 << $urandom_range(0, 15));
                default: sw_raw = sw_raw;
            endcase
            repeat ($urandom_range(1, 30)) begin
                irq_ack = ($urandom_range(0, 3) == 0);
                step(1);
            end
        end
        irq_ack = 1'b0;

        // Mid-operation reset
        sw_raw = 16'hFFFF;
        step(30);
        check("pre_reset_swh", 32'(swh), 32'hFF);
        check("pre_reset_swl", 32'(swl), 32'hFF);
        #2 rst = 1'b1;
        #1;
        check_zero_outputs("async_reset");
        step(2);
        rst = 1'b0;
        step(11);
        check("rerun_valid_before_12", 32'(valid), 32'd0);
        step(1);
        check("rerun_valid_at_12", 32'(valid), 32'd1);
        check("rerun_swh", 32'(swh), 32'hFF);
        check("rerun_swl", 32'(swl), 32'hFF);

        step(20);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/switch_conditioner.md
# switch_conditioner

Input conditioning stage for the 16 board slide switches, directly upstream of the memory-mapped `Switches` peripheral. Synchronises the raw asynchronous pins to `CLK` and debounces each bit on a shared sample tick. Drives the stable `SWH`/`SWL` bytes that the peripheral returns to the CPU at bus addresses 0xE1/0xE0. Also flags debounced changes so software can poll or take an interrupt instead of re-reading both bytes.

## Interface

Parameters:
- `TICK_DIV`, 100000 — `CLK` cycles per sample tick; legal range ≥ 2. The default gives 1 ms at 100 MHz.
- `STABLE_SAMPLES`, 4 — consecutive agreeing samples required to accept a new level; legal range 2..8.

Ports:
- `CLK`  in  1  system clock.
- `RESET`  in  1  asynchronous, active-high reset.
- `SW_RAW`  in  16  raw switch pins; bits [15:8] are the high bank, [7:0] the low bank.
- `SWH`  out  8  debounced high bank, feeds `Switches.SWH`.
- `SWL`  out  8  debounced low bank, feeds `Switches.SWL`.
- `VALID`  out  1  high once the first full sample window has completed.
- `CHANGED`  out  1  one-cycle pulse on any debounced bit change.
- `CHANGE_MASK`  out  16  bits that changed in the `CHANGED` cycle; zero otherwise.
- `IRQ`  out  1  latched change interrupt; present only with the macro.
- `IRQ_ACK`  in  1  clears `IRQ`.

## Operation

- **Synchroniser:** a 2-flop chain per bit produces `sw_sync`.
- **Prescaler:**
  - `tick_cnt` counts 0..TICK_DIV-1 and wraps.
  - `tick` is asserted combinationally while `tick_cnt == TICK_DIV-1`.
- **History:** each bit has a `STABLE_SAMPLES`-bit shift register. On a `tick` edge, `hist_n = {hist[N-2:0], sw_sync}`.
- **Debounce rule:**
  - On a `tick` edge, if `hist_n` is all ones the output bit becomes 1.
  - If `hist_n` is all zeros, it becomes 0.
  - Otherwise the bit holds its value.
  - Bits are independent.
- **Warm-up state machine:**
  - States are WARMUP and RUN.
  - `warm_cnt` counts ticks while in WARMUP.
  - On the `STABLE_SAMPLES`-th tick, the FSM enters RUN and `VALID` rises on that same edge.
  - Outputs are loaded per the debounce rule on that edge.
  - `CHANGED` is suppressed on that edge and throughout WARMUP.
- **Change detect (RUN only):**
  - `CHANGE_MASK` = old XOR new debounced value, registered on the update edge.
  - `CHANGED` = OR of `CHANGE_MASK`.
  - Both return to 0 on the next edge.
- **Bouncing input:** an input that toggles at least once per window never updates its output bit.

## Timing

- **Reset values:** `SWH=0x00`, `SWL=0x00`, `VALID=0`, `CHANGED=0`, `CHANGE_MASK=0`, `IRQ=0`. History registers, synchronisers, `tick_cnt` and `warm_cnt` all reset to 0, and the FSM resets to WARMUP.
- **Reset mid-operation:** all state clears immediately, regardless of any tick in progress.
- **Latency:**
  - A clean level change on `SW_RAW` appears on `SWH`/`SWL` after 2 + (STABLE_SAMPLES-1)·TICK_DIV + 1 cycles at minimum.
  - At maximum it appears after 2 + STABLE_SAMPLES·TICK_DIV cycles.
- **Post-reset:** `VALID` rises exactly STABLE_SAMPLES·TICK_DIV cycles after `RESET` deasserts.
- **Output register timing:**
  - Outputs change only on `tick` edges.
  - Between ticks, `SWH`/`SWL` are stable registers, so a single-cycle bus read in `Switches` always sees a coherent 16-bit value.
- **Simultaneous changes:** several bits qualifying on the same tick produce one `CHANGED` pulse, with all of those bits set in `CHANGE_MASK`.

## Configuration

- **`SW_CHANGE_IRQ_EN` defined:**
  - `IRQ` is set on any `CHANGED` pulse.
  - It is cleared on an edge with `IRQ_ACK=1` and no `CHANGED`.
  - If `CHANGED` and `IRQ_ACK` coincide, `IRQ` stays 1, so no event is lost.
- **`SW_CHANGE_IRQ_EN` undefined:** `IRQ` is tied to 0, `IRQ_ACK` is ignored, and no IRQ flop is synthesised.

## Test plan

All scenarios use `TICK_DIV=4`, `STABLE_SAMPLES=3`.

- **Reset/warm-up:** hold `SW_RAW=0x0001` through reset, then release → `VALID` rises exactly 12 cycles after release, with `SWL=0x01`, `SWH=0x00` and no `CHANGED` pulse.
- **Clean change:** in RUN, step `SW_RAW` 0x0001→0xFF01 → `SWH=0xFF` within 2+12 cycles, one `CHANGED` pulse, `CHANGE_MASK=0xFF00`, `SWL` unchanged.
- **Bounce rejection:** toggle bit 0 every 5 cycles for 60 cycles → `SWL[0]` never changes and `CHANGED` stays 0. Then hold bit 0 at 0 → `SWL=0x00` within 14 cycles and `CHANGE_MASK=0x0001`.
- **Glitch:** a single-cycle 1 on bit 9 landing on a tick → no output change.
- **IRQ (macro defined):**
  - A change sets `IRQ`, and `IRQ_ACK` clears it on the next edge.
  - With `IRQ_ACK` asserted on the same edge as a new `CHANGED`, `IRQ` remains 1.
  - With the macro undefined, `IRQ` stays 0 throughout.
- **Mid-operation reset:** assert `RESET` while `SW_RAW=0xFFFF` is settled → all outputs return to 0 asynchronously and `VALID` re-rises 12 cycles after release.
